// File: rtl/fix_arith_pkg.sv
// Shared definitions for the fixed-point arithmetic responders:
// default formats, FSM states and saturation limits.
package fix_arith_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_FRAC  = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    NORM = 2'd2
  } state_e;

  // Largest positive value of a width-bit two's complement number.
  function automatic logic [63:0] max_pos(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Bit pattern of the most negative value; zero-extended it also equals its magnitude.
  function automatic logic [63:0] min_neg(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/fix_mul_seq_if.sv
// Start/done arithmetic handshake between the bin-correction sequencer (master)
// and an arithmetic responder (slave).
interface fix_mul_seq_if #(
  parameter int WIDTH = fix_arith_pkg::DEF_WIDTH
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             start;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             ovf;

  modport master (output a, b, start, input result, done, busy, ovf);
  modport slave  (input a, b, start, output result, done, busy, ovf);
endinterface

// File: rtl/fix_round_sat.sv
// Turns an unsigned double-width product magnitude plus a sign into a rounded
// (half away from zero), saturated fixed-point result with an overflow flag.
module fix_round_sat
  import fix_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic [2*WIDTH-1:0] prod_mag,
  input  logic               sign,
  output logic [WIDTH-1:0]   result,
  output logic               ovf
);

  localparam int            PW      = 2 * WIDTH + 1;
  localparam logic [PW-1:0] HALF    = PW'(1) << (FRAC - 1);
  localparam logic [PW-1:0] LIM_POS = PW'(max_pos(WIDTH));
  localparam logic [PW-1:0] LIM_NEG = PW'(min_neg(WIDTH));

  logic [PW-1:0] rounded;
  logic [PW-1:0] mag;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    result  = '0;
    ovf     = 1'b0;
    rounded = {1'b0, prod_mag} + HALF;
    mag     = rounded >> FRAC;
    if (!sign) begin
      if (mag > LIM_POS) begin
        result = LIM_POS[WIDTH-1:0];
        ovf    = 1'b1;
      end else begin
        result = mag[WIDTH-1:0];
      end
    end else begin
      // A magnitude of exactly 2^(WIDTH-1) negates cleanly to the most negative code.
      if (mag > LIM_NEG) begin
        result = LIM_NEG[WIDTH-1:0];
        ovf    = 1'b1;
      end else begin
        result = '0 - mag[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/fix_mul_seq.sv
// Serial signed fixed-point multiplier: one shift-add step per cycle on operand
// magnitudes, then a single normalisation cycle that raises done.
module fix_mul_seq
  import fix_arith_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic          clk,
  input  logic          rst,
  fix_mul_seq_if.slave  bus
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 sign_q, sign_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     rs_result;
  logic                 rs_ovf;

  // Unsigned magnitudes so that |-2^(WIDTH-1)| stays representable.
  always_comb begin
    a_mag = bus.a[WIDTH-1] ? ('0 - bus.a) : bus.a;
    b_mag = bus.b[WIDTH-1] ? ('0 - bus.b) : bus.b;
  end

  fix_round_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_round_sat (
    .prod_mag (acc_q),
    .sign     (sign_q),
    .result   (rs_result),
    .ovf      (rs_ovf)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    sign_d   = sign_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = {{WIDTH{1'b0}}, a_mag};
          mplier_d = b_mag;
          sign_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = MULT;
        end
      end
      MULT: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST) state_d = NORM;
      end
      NORM: begin
        result_d = rs_result;
        ovf_d    = rs_ovf;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments, and the asynchronous reset clears
  // every flop so an aborted operation leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      sign_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      sign_q   <= sign_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_fix_mul_seq.sv
// Self-checking bench for fix_mul_seq: directed literal cases plus randomized
// traffic compared every cycle against an arithmetic reference model.
module tb_fix_mul_seq;

  localparam int WIDTH = 24;
  localparam int FRAC  = 12;

  logic clk = 1'b0;
  logic rst;
  logic cmp_en;
  int   total = 0;
  int   bad   = 0;
  int   n_dut_done = 0;
  int   n_exp_done = 0;

  fix_mul_seq_if #(.WIDTH(WIDTH)) bus ();

  fix_mul_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Reference: signed product from plain integer arithmetic, then the rounding/saturation rules.
  function automatic logic [WIDTH:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    longint p, mag, m, maxp, minm, neg;
    logic [WIDTH-1:0] r;
    logic o;
    logic s;
    p    = longint'($signed(x)) * longint'($signed(y));
    mag  = (p < 0) ? -p : p;
    m    = (mag + (longint'(1) << (FRAC - 1))) >> FRAC;
    maxp = (longint'(1) << (WIDTH - 1)) - 1;
    minm = longint'(1) << (WIDTH - 1);
    s    = x[WIDTH-1] ^ y[WIDTH-1];
    o    = 1'b0;
    if (!s) begin
      if (m > maxp) begin r = maxp[WIDTH-1:0]; o = 1'b1; end
      else          r = m[WIDTH-1:0];
    end else begin
      if (m > minm) begin neg = -minm; o = 1'b1; end
      else          neg = -m;
      r = neg[WIDTH-1:0];
    end
    return {o, r};
  endfunction

  // Timing model: an accepted request completes WIDTH+1 edges later.
  logic             exp_busy, exp_done, exp_ovf;
  logic [WIDTH-1:0] exp_result, pend_a, pend_b;
  int               remaining;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_busy   <= 1'b0;
      exp_done   <= 1'b0;
      exp_ovf    <= 1'b0;
      exp_result <= '0;
      remaining  <= 0;
    end else begin
      exp_done <= 1'b0;
      if (exp_busy) begin
        remaining <= remaining - 1;
        if (remaining == 1) begin
          exp_busy <= 1'b0;
          exp_done <= 1'b1;
          {exp_ovf, exp_result} <= ref_mul(pend_a, pend_b);
        end
      end else if (bus.start) begin
        exp_busy  <= 1'b1;
        remaining <= WIDTH + 1;
        pend_a    <= bus.a;
        pend_b    <= bus.b;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmp_en) begin
      check("busy", bus.busy, exp_busy);
      check("done", bus.done, exp_done);
      check("result", bus.result, exp_result);
      check("ovf", bus.ovf, exp_ovf);
      if (bus.done) n_dut_done++;
      if (exp_done) n_exp_done++;
    end
  end

  // lat = edges from acceptance to the edge that raised done.
  task automatic wait_done(output int lat, output logic seen);
    seen = 1'b0;
    lat  = 0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        lat  = c - 1;
      end
    end
  endtask

  task automatic run_op(input string nm, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                        input logic [WIDTH-1:0] er, input logic eo);
    int   lat;
    logic seen;
    @(posedge clk); #1;
    bus.a = ta; bus.b = tbv; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~ta; bus.b = ~tbv;
    wait_done(lat, seen);
    check({nm, "_seen"}, seen, 1'b1);
    check({nm, "_lat"}, lat, WIDTH + 1);
    check({nm, "_res"}, bus.result, er);
    check({nm, "_ovf"}, bus.ovf, eo);
    @(negedge clk);
    check({nm, "_done_low"}, bus.done, 1'b0);
    check({nm, "_busy_low"}, bus.busy, 1'b0);
  endtask

  function automatic logic [WIDTH-1:0] pick();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 6))
      0:       return 24'h800000;
      1:       return 24'h7FFFFF;
      2:       return {{8{r[15]}}, r[15:0]};
      3:       return 24'h000000;
      default: return r[WIDTH-1:0];
    endcase
  endfunction

  initial begin
    int   lat;
    logic seen;
    int   extra;
    rst = 1'b1; cmp_en = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    check("rst_result", bus.result, 24'h0);
    check("rst_done", bus.done, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ovf", bus.ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0; cmp_en = 1'b1;

    run_op("p1p5x2",   24'h001800, 24'h002000, 24'h003000, 1'b0);
    run_op("n1p5x2",   24'hFFE800, 24'h002000, 24'hFFD000, 1'b0);
    run_op("half_up",  24'h000001, 24'h000800, 24'h000001, 1'b0);
    run_op("half_neg", 24'hFFFFFF, 24'h000800, 24'hFFFFFF, 1'b0);
    run_op("sat_pos",  24'h400000, 24'h002000, 24'h7FFFFF, 1'b1);
    run_op("min_sq",   24'h800000, 24'h800000, 24'h7FFFFF, 1'b1);
    run_op("exact_mn", 24'hC00000, 24'h002000, 24'h800000, 1'b0);

    // Start while busy must be ignored.
    @(posedge clk); #1;
    bus.a = 24'h001000; bus.b = 24'h003000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.a = 24'h002000; bus.b = 24'h002000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, seen);
    check("ign_seen", seen, 1'b1);
    check("ign_res", bus.result, 24'h003000);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("ign_extra_done", extra, 0);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #1;
    bus.a = 24'h002800; bus.b = 24'hFFF000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_result", bus.result, 24'h0);
    check("abort_done", bus.done, 1'b0);
    check("abort_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) extra++;
    end
    check("abort_no_done", extra, 0);
    run_op("post_rst", 24'h002800, 24'hFFF000, 24'hFFD800, 1'b0);

    // Back-to-back: second start presented during the done cycle.
    @(posedge clk); #1;
    bus.a = 24'h001800; bus.b = 24'hFFE000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, seen);
    check("b2b1_seen", seen, 1'b1);
    check("b2b1_res", bus.result, 24'hFFD000);
    bus.a = 24'h7FFFFF; bus.b = 24'h001000; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, seen);
    check("b2b2_seen", seen, 1'b1);
    check("b2b2_lat", lat, WIDTH + 1);
    check("b2b2_res", bus.result, 24'h7FFFFF);
    check("b2b2_ovf", bus.ovf, 1'b0);

    // Randomized traffic, including starts while busy and on done cycles.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      bus.start = ($urandom_range(0, 3) == 0);
      bus.a = pick();
      bus.b = pick();
    end
    bus.start = 1'b0;
    repeat (WIDTH + 5) @(posedge clk);
    @(negedge clk);
    check("done_count", n_dut_done, n_exp_done);
    check("rand_activity", n_exp_done > 40, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
